// File: rtl/srm_pkg.sv
// Shared instruction-set constants for the fetch unit and its decoder.
// Field positions are given as bit indices into the 16-bit instruction word.
package srm_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] RSEL_RM = 2'b00;
  localparam logic [1:0] RSEL_RD = 2'b01;
  localparam logic [1:0] RSEL_RN = 2'b10;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int ALU_MSB  = 12;
  localparam int ALU_LSB  = 11;
  localparam int RN_MSB   = 10;
  localparam int RN_LSB   = 8;
  localparam int RD_MSB   = 7;
  localparam int RD_LSB   = 5;
  localparam int SH_MSB   = 4;
  localparam int SH_LSB   = 3;
  localparam int RM_MSB   = 2;
  localparam int RM_LSB   = 0;
  localparam int IMM8_MSB = 7;
  localparam int IMM5_MSB = 4;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] alu_op;
    logic [1:0] shift_op;
  } dec_ctl_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational split of the instruction register into controller fields,
// register-address steering and sign-extended immediates.
module instr_decoder
  import srm_pkg::*;
(
  input  logic [INSTR_W-1:0]        ir,
  input  logic [1:0]                reg_sel,
  output logic [2:0]                opcode,
  output logic [1:0]                ALU_op,
  output logic [1:0]                shift_op,
  output logic [2:0]                r_addr,
  output logic signed [INSTR_W-1:0] imm8_sx,
  output logic signed [INSTR_W-1:0] imm5_sx
);

  dec_ctl_t ctl;

  function automatic logic signed [INSTR_W-1:0] sx8(input logic [IMM8_MSB:0] v);
    return {{(INSTR_W-IMM8_MSB-1){v[IMM8_MSB]}}, v};
  endfunction

  function automatic logic signed [INSTR_W-1:0] sx5(input logic [IMM5_MSB:0] v);
    return {{(INSTR_W-IMM5_MSB-1){v[IMM5_MSB]}}, v};
  endfunction

  assign ctl.opcode   = ir[OPC_MSB:OPC_LSB];
  assign ctl.alu_op   = ir[ALU_MSB:ALU_LSB];
  assign ctl.shift_op = ir[SH_MSB:SH_LSB];

  assign opcode   = ctl.opcode;
  assign ALU_op   = ctl.alu_op;
  assign shift_op = ctl.shift_op;

  assign imm8_sx = sx8(ir[IMM8_MSB:0]);
  assign imm5_sx = sx5(ir[IMM5_MSB:0]);

  // The reserved select code reads as register 0 rather than leaving the port undefined.
  always_comb begin
    r_addr = 3'd0;
    case (reg_sel)
      RSEL_RM: r_addr = ir[RM_MSB:RM_LSB];
      RSEL_RD: r_addr = ir[RD_MSB:RD_LSB];
      RSEL_RN: r_addr = ir[RN_MSB:RN_LSB];
      default: r_addr = 3'd0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: requests words from instruction memory, latches them
// in the IR, pulses start to the controller and waits for it to become idle again.
module instr_fetch_unit
  import srm_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PC_W-1:0]           mem_addr,
  output logic                      mem_rd,
  input  logic [INSTR_W-1:0]        mem_rdata,
  input  logic                      mem_valid,
  input  logic                      waiting,
  input  logic [1:0]                reg_sel,
  output logic                      start,
  output logic [2:0]                opcode,
  output logic [1:0]                ALU_op,
  output logic [1:0]                shift_op,
  output logic [2:0]                r_addr,
  output logic signed [INSTR_W-1:0] imm8_sx,
  output logic signed [INSTR_W-1:0] imm5_sx,
  output logic                      halted,
  output logic                      fault
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [PC_W-1:0]  PC_INIT   = PC_W'(RESET_PC);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_HALT  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (mem_valid) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PC_W'(1);
          cnt_d   = '0;
          state_d = (mem_rdata[OPC_MSB:OPC_LSB] == OP_HALT) ? S_HALT : S_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TIMEOUT_C) state_d = S_FAULT;
        end
      end
      S_ISSUE: state_d = S_BUSY;
      // A controller that never dropped waiting still releases us here; start is not re-issued.
      S_BUSY:  if (waiting) state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= PC_INIT;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control outputs are masked while rst is held so nothing leaks during the reset cycle.
  assign mem_addr = pc_q;
  assign mem_rd   = (state_q == S_FETCH) && !rst;
  assign start    = (state_q == S_ISSUE) && !rst;
  assign halted   = (state_q == S_HALT)  && !rst;
  assign fault    = (state_q == S_FAULT) && !rst;

  instr_decoder u_dec (
    .ir       (ir_q),
    .reg_sel  (reg_sel),
    .opcode   (opcode),
    .ALU_op   (ALU_op),
    .shift_op (shift_op),
    .r_addr   (r_addr),
    .imm8_sx  (imm8_sx),
    .imm5_sx  (imm5_sx)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one 8-bit-PC instance for the main flow,
// one 2-bit-PC instance for address wrap and mid-read reset.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // 8-bit PC instance
  logic        rst, mem_valid, waiting;
  logic [15:0] mem_rdata;
  logic [1:0]  reg_sel;
  logic [7:0]  mem_addr;
  logic        mem_rd, start, halted, fault;
  logic [2:0]  opcode, r_addr;
  logic [1:0]  alu_op, shift_op;
  logic [15:0] imm8_sx, imm5_sx;

  // 2-bit PC instance
  logic        rst2, mem_valid2, waiting2;
  logic [15:0] mem_rdata2;
  logic [1:0]  mem_addr2;
  logic        mem_rd2, start2, halted2, fault2;
  logic [2:0]  opcode2, r_addr2;
  logic [1:0]  alu_op2, shift_op2;
  logic [15:0] imm8_sx2, imm5_sx2;

  instr_fetch_unit #(.PC_W(8), .RESET_PC(0), .MEM_TIMEOUT(15)) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .waiting(waiting), .reg_sel(reg_sel), .start(start),
    .opcode(opcode), .ALU_op(alu_op), .shift_op(shift_op), .r_addr(r_addr),
    .imm8_sx(imm8_sx), .imm5_sx(imm5_sx), .halted(halted), .fault(fault)
  );

  instr_fetch_unit #(.PC_W(2), .RESET_PC(0), .MEM_TIMEOUT(15)) u_dut2 (
    .clk(clk), .rst(rst2), .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_rdata(mem_rdata2),
    .mem_valid(mem_valid2), .waiting(waiting2), .reg_sel(2'b00), .start(start2),
    .opcode(opcode2), .ALU_op(alu_op2), .shift_op(shift_op2), .r_addr(r_addr2),
    .imm8_sx(imm8_sx2), .imm5_sx(imm5_sx2), .halted(halted2), .fault(fault2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [15:0] words2 [5] = '{16'hA0F3, 16'hD105, 16'hD2F0, 16'h5123, 16'hD105};
  logic [1:0]  addr2  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [2:0]  op2    [5] = '{3'd5, 3'd6, 3'd6, 3'd2, 3'd6};
  logic [15:0] imm5e  [5] = '{16'hFFF3, 16'h0005, 16'hFFF0, 16'h0003, 16'h0005};
  logic [1:0]  sh2    [5] = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0};

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_rdata = 16'h0; waiting = 1'b1; reg_sel = 2'b00;
    rst2 = 1'b1; mem_valid2 = 1'b0; mem_rdata2 = 16'h0; waiting2 = 1'b1;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_start", start, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ir", {opcode, imm8_sx}, 0);

    // MOV R1,#5 after one cycle of latency
    rst = 1'b0;
    #1;
    chk("f0_mem_rd", mem_rd, 1);
    chk("f0_addr", mem_addr, 0);
    tick();
    mem_valid = 1'b1; mem_rdata = 16'hD105;
    #1;
    chk("f0_no_start", start, 0);
    tick();
    mem_valid = 1'b0; reg_sel = 2'b10;
    #1;
    chk("mov_start", start, 1);
    chk("mov_opcode", opcode, 3'b110);
    chk("mov_aluop", alu_op, 2'b10);
    chk("mov_raddr_rn", r_addr, 3'd1);
    chk("mov_imm8", imm8_sx, 16'h0005);
    chk("issue_mem_rd", mem_rd, 0);
    reg_sel = 2'b01;
    #1;
    chk("mov_raddr_rd", r_addr, 3'd0);
    reg_sel = 2'b11;
    #1;
    chk("mov_raddr_rsv", r_addr, 3'd0);

    // Controller busy for six cycles
    for (int i = 0; i < 6; i++) begin
      tick();
      waiting = 1'b0;
      #1;
      chk("busy_start", start, 0);
      chk("busy_mem_rd", mem_rd, 0);
    end
    tick();
    waiting = 1'b1;
    #1;
    chk("busy_last_mem_rd", mem_rd, 0);
    tick();
    #1;
    chk("refetch_mem_rd", mem_rd, 1);
    chk("refetch_addr", mem_addr, 1);

    // Negative imm8
    tick();
    mem_valid = 1'b1; mem_rdata = 16'hD2F0;
    tick();
    mem_valid = 1'b0;
    #1;
    chk("neg_start", start, 1);
    chk("neg_imm8", imm8_sx, 16'hFFF0);
    chk("neg_pc", mem_addr, 2);
    tick(); waiting = 1'b0;
    tick(); waiting = 1'b1;
    tick();
    #1;
    chk("f2_addr", mem_addr, 2);

    // HALT at PC=2
    tick();
    mem_valid = 1'b1; mem_rdata = 16'hE000;
    tick();
    mem_valid = 1'b0;
    #1;
    chk("halt_halted", halted, 1);
    chk("halt_start", start, 0);
    chk("halt_mem_rd", mem_rd, 0);
    mem_valid = 1'b1; mem_rdata = 16'hD105;
    tick(); tick(); tick();
    #1;
    chk("halt_sticky", halted, 1);
    chk("halt_ir_kept", opcode, 3'b111);
    chk("halt_pc", mem_addr, 3);
    chk("halt_no_start", start, 0);
    mem_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_pc", mem_addr, 0);

    // Memory timeout
    repeat (14) tick();
    #1;
    chk("to_mem_rd_15", mem_rd, 1);
    chk("to_fault_15", fault, 0);
    tick();
    #1;
    chk("to_fault", fault, 1);
    chk("to_mem_rd", mem_rd, 0);
    mem_valid = 1'b1; mem_rdata = 16'hD105;
    tick(); tick();
    #1;
    chk("to_late_fault", fault, 1);
    chk("to_late_ir", opcode, 3'b000);
    chk("to_late_start", start, 0);
    mem_valid = 1'b0;

    // PC_W=2 wrap with a cooperative controller
    tick();
    rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wrap_addr", mem_addr2, addr2[i]);
      tick();
      mem_valid2 = 1'b1; mem_rdata2 = words2[i];
      tick();
      mem_valid2 = 1'b0;
      #1;
      chk("wrap_start", start2, 1);
      chk("wrap_opcode", opcode2, op2[i]);
      chk("wrap_imm5", imm5_sx2, imm5e[i]);
      chk("wrap_shift", shift_op2, sh2[i]);
      tick(); waiting2 = 1'b0;
      tick(); waiting2 = 1'b1;
      tick();
    end
    #1;
    chk("wrap_addr_after", mem_addr2, 1);

    // Reset coinciding with mem_valid mid-read
    tick();
    rst2 = 1'b1; mem_valid2 = 1'b1; mem_rdata2 = 16'hE000;
    tick();
    rst2 = 1'b0; mem_valid2 = 1'b0;
    #1;
    chk("midrst_ir", {opcode2, imm8_sx2}, 0);
    chk("midrst_pc", mem_addr2, 0);
    chk("midrst_halted", halted2, 0);
    chk("midrst_mem_rd", mem_rd2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
